serial_adder_ctrl: RTL and testbench

Bit-serial N-bit adder front end. It accepts two WIDTH-bit operands plus carry-in through a valid/ready handshake. It then drives one full-adder cell LSB-first, one bit per clock, with the carry held in a flip-flop between bits. The block feeds the 1-bit full-adder stage (A, B, Ci in; S, Co out), collects S into a result shift register and returns sum plus carry-out through a second valid/ready handshake.

---
 rtl/serial_adder_ctrl.sv | 101 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder with one full-adder cell
// and valid/ready handshakes on both the operand and result sides.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             fa_s, fa_co;

    assign fa_s  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_co = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sum       = sum_q;
    assign cout      = cout_q;

    // sum/cout are only written on the final bit so they hold the previous result while shifting
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_co;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed plus randomized checks of serial_adder_ctrl against
// a cycle-level model built from latency/handshake rules and plain a+b+cin.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout;
    logic [W-1:0] sum;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: accept when idle, result appears W edges later, held until taken.
    logic         m_ready = 1'b1, m_valid = 1'b0, m_cout = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic [W:0]   m_res = '0;
    int           m_cnt = 0, acc_cnt = 0;
    logic [W:0]   exp_arr [4096];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_cout  <= 1'b0;
            m_sum   <= '0;
            m_cnt   <= 0;
        end else if (m_ready && in_valid) begin
            m_res   <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            exp_arr[acc_cnt % 4096] <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            acc_cnt <= acc_cnt + 1;
            m_ready <= 1'b0;
            m_cnt   <= W;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                {m_cout, m_sum} <= m_res;
                m_valid <= 1'b1;
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end
    end

    int rd_idx = 0, recv = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) rd_idx = acc_cnt;
            else begin
                chk("cycle {in_ready,out_valid,cout,sum}", {in_ready, out_valid, cout, sum},
                    {m_ready, m_valid, m_cout, m_sum});
                if (out_valid && out_ready) begin
                    if (rd_idx == acc_cnt) chk("unexpected result", {cout, sum}, 64'hDEAD);
                    else chk("ordered result", {cout, sum}, exp_arr[rd_idx % 4096]);
                    rd_idx++;
                    recv++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                           input logic [W-1:0] es, input logic ec, input string name);
        int n;
        in_valid = 1'b1; a = xa; b = xb; cin = xc;
        tick();
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({name, " latency"}, n, W);
        chk({name, " sum"}, sum, es);
        chk({name, " cout"}, cout, ec);
    endtask

    initial begin
        int prev, target, start_recv, cyc;
        logic seen;
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset sum/cout", {cout, sum}, 0);
        tick();
        rst = 1'b0;
        tick();

        out_ready = 1'b1;
        run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "12+34");
        tick();
        chk("in_ready after handshake", in_ready, 1);
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "FF+01");
        tick();
        run_add(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, "5A+A5+1");
        tick();
        run_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "00+00");
        tick();

        out_ready = 1'b0;
        run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "bp 12+34");
        in_valid = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        repeat (20) begin
            tick();
            chk("bp hold", {out_valid, in_ready, cout, sum}, {1'b1, 1'b0, 1'b0, 8'h46});
        end
        out_ready = 1'b1;
        tick();
        chk("bp release in_ready", in_ready, 1);
        tick();
        chk("bp accept next", in_ready, 0);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("bp next sum", {cout, sum}, 9'h003);
        tick();

        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("async reset outputs", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, 8'h00});
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            tick();
            seen |= out_valid;
        end
        chk("no out_valid after abort", seen, 0);
        run_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "0F+01");
        tick();

        target = acc_cnt + 1000;
        start_recv = recv;
        prev = acc_cnt;
        cyc = 0;
        while (acc_cnt < target && cyc < 60000) begin
            out_ready = $urandom_range(0, 9) < 6;
            if (!(in_valid && acc_cnt == prev)) begin
                prev = acc_cnt;
                in_valid = $urandom_range(0, 3) != 0;
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("random words accepted", acc_cnt, target);
        cyc = 0;
        while (rd_idx != acc_cnt && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("random results received", recv - start_recv, 1000);
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
